// File: rtl/mem_wb_writer.sv
// Write-back stage: buffers the incoming result stream in a small FIFO and
// writes it to consecutive destination addresses for a programmed word count.
module mem_wb_writer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic fifo_empty_s;
  logic fifo_full_s;
  logic in_ready_s;
  logic push_s;
  logic pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready_s   = (state_q == S_RUN) && !fifo_full_s && (acc_cnt_q < len_q);
  assign push_s       = in_valid && in_ready_s;
  assign pop_s        = (state_q == S_RUN) && !fifo_empty_s;

  // Next-state, counter, pointer and write-port logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = (state_q == S_RUN);
    done_d    = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          len_d     = length;
          acc_cnt_d = {CNT_W{1'b0}};
          wr_cnt_d  = {CNT_W{1'b0}};
          if (length == {CNT_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (push_s) begin
          wr_ptr_d  = wr_ptr_q + PTR_ONE;
          acc_cnt_d = acc_cnt_q + CNT_ONE;
        end else begin
          wr_ptr_d  = wr_ptr_q;
          acc_cnt_d = acc_cnt_q;
        end
        // The head word is written out unconditionally; the sink never stalls.
        if (pop_s) begin
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
          addr_d    = addr_q + ADDR_ONE;
          wr_cnt_d  = wr_cnt_q + CNT_ONE;
          if (wr_cnt_d == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          wr_en_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state plus its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Transfer registers, FIFO pointers and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= {ADDR_W{1'b0}};
      len_q     <= {CNT_W{1'b0}};
      acc_cnt_q <= {CNT_W{1'b0}};
      wr_cnt_q  <= {CNT_W{1'b0}};
      wr_ptr_q  <= {(PTR_W+1){1'b0}};
      rd_ptr_q  <= {(PTR_W+1){1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
    end
  end

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
